simple_ifetch: RTL and testbench



---
 rtl/simple_ifetch_if.sv | 24 ++
 rtl/simple_ifetch.sv | 144 ++++++++++++++
 tb/tb_simple_ifetch.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/simple_ifetch_if.sv
// Fetch-stage bus: instruction memory port, decode-side control and the F/D register.
interface simple_ifetch_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_rdata;
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic [15:0]       inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              halted;

    modport master (
        output imem_addr, inst, inst_pc, inst_valid, halted,
        input  imem_rdata, stall, branch_taken, branch_target
    );

    modport slave (
        input  imem_addr, inst, inst_pc, inst_valid, halted,
        output imem_rdata, stall, branch_taken, branch_target
    );
endinterface

// File: rtl/simple_ifetch.sv
// Instruction fetch for the SIMPLE 16-bit pipeline: PC, sync-read imem, skid-backed
// F/D register with stall, branch redirect/flush and halt self-detection.
module simple_ifetch #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [15:0]       NOP_INST = 16'hC0E0
) (
    input logic               clk,
    input logic               rst_n,
    simple_ifetch_if.master   bus
);
    localparam logic [0:0] S_RUN    = 1'b0;
    localparam logic [0:0] S_HALTED = 1'b1;

    logic [0:0]        state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic              ifv, ifv_nxt;
    logic [ADDR_W-1:0] ifpc, ifpc_nxt;
    logic              skv, skv_nxt;
    logic [15:0]       skid, skid_nxt;
    logic [ADDR_W-1:0] skid_pc, skid_pc_nxt;
    logic [15:0]       inst, inst_nxt;
    logic [ADDR_W-1:0] inst_pc, inst_pc_nxt;
    logic              inst_valid, inst_valid_nxt;
    logic              halted, halted_nxt;
    logic              load;
    logic [15:0]       load_word;
    logic [ADDR_W-1:0] load_pc;

    function automatic logic is_hlt(input logic [15:0] w);
        return (w[15:14] == 2'b11) && (w[7:4] == 4'hF);
    endfunction

    assign bus.imem_addr  = pc;
    assign bus.inst       = inst;
    assign bus.inst_pc    = inst_pc;
    assign bus.inst_valid = inst_valid;
    assign bus.halted     = halted;

    // Next-state: branch beats stall beats normal fetch.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        ifv_nxt        = ifv;
        ifpc_nxt       = ifpc;
        skv_nxt        = skv;
        skid_nxt       = skid;
        skid_pc_nxt    = skid_pc;
        inst_nxt       = inst;
        inst_pc_nxt    = inst_pc;
        inst_valid_nxt = inst_valid;
        halted_nxt     = halted;
        load           = 1'b0;
        load_word      = skid;
        load_pc        = skid_pc;

        if (bus.branch_taken) begin
            pc_nxt         = bus.branch_target;
            ifv_nxt        = 1'b0;
            skv_nxt        = 1'b0;
            inst_nxt       = NOP_INST;
            inst_valid_nxt = 1'b0;
            halted_nxt     = 1'b0;
            state_nxt      = S_RUN;
        end else if (state == S_HALTED) begin
            ifv_nxt = 1'b0;
            skv_nxt = 1'b0;
            if (!bus.stall) begin
                inst_nxt       = NOP_INST;
                inst_valid_nxt = 1'b0;
            end
        end else if (bus.stall) begin
            // Park the returning read so the held PC can be refetched without loss.
            if (ifv && !skv) begin
                skid_nxt    = bus.imem_rdata;
                skid_pc_nxt = ifpc;
                skv_nxt     = 1'b1;
            end
            ifv_nxt = 1'b0;
        end else begin
            pc_nxt   = pc + ADDR_W'(1);
            ifv_nxt  = 1'b1;
            ifpc_nxt = pc;
            if (skv) begin
                load = 1'b1;
                if (ifv) begin
                    skid_nxt    = bus.imem_rdata;
                    skid_pc_nxt = ifpc;
                end else begin
                    skv_nxt = 1'b0;
                end
            end else if (ifv) begin
                load      = 1'b1;
                load_word = bus.imem_rdata;
                load_pc   = ifpc;
            end else begin
                inst_nxt       = NOP_INST;
                inst_valid_nxt = 1'b0;
            end

            if (load) begin
                inst_nxt       = load_word;
                inst_pc_nxt    = load_pc;
                inst_valid_nxt = 1'b1;
                // HLT stops fetch on the edge it is delivered; younger fetches are dropped.
                if (is_hlt(load_word)) begin
                    state_nxt  = S_HALTED;
                    halted_nxt = 1'b1;
                    ifv_nxt    = 1'b0;
                    skv_nxt    = 1'b0;
                    pc_nxt     = pc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_RUN;
            pc         <= RESET_PC;
            ifv        <= 1'b0;
            ifpc       <= '0;
            skv        <= 1'b0;
            skid       <= NOP_INST;
            skid_pc    <= '0;
            inst       <= NOP_INST;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            ifv        <= ifv_nxt;
            ifpc       <= ifpc_nxt;
            skv        <= skv_nxt;
            skid       <= skid_nxt;
            skid_pc    <= skid_pc_nxt;
            inst       <= inst_nxt;
            inst_pc    <= inst_pc_nxt;
            inst_valid <= inst_valid_nxt;
            halted     <= halted_nxt;
        end
    end
endmodule

// File: tb/tb_simple_ifetch.sv
// Directed bench for simple_ifetch with a synchronous-read memory model.
module tb_simple_ifetch;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] mem [0:65535];

    always #5 clk = ~clk;

    simple_ifetch_if #(.ADDR_W(16)) bus ();

    simple_ifetch #(
        .ADDR_W  (16),
        .RESET_PC(16'h0000),
        .NOP_INST(16'hC0E0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_f(input string tag, input logic [15:0] i, input logic [15:0] p, input logic v);
        check({tag, ".inst"},  32'(bus.inst),       32'(i));
        check({tag, ".pc"},    32'(bus.inst_pc),    32'(p));
        check({tag, ".valid"}, 32'(bus.inst_valid), 32'(v));
    endtask

    task automatic branch(input logic [15:0] t);
        bus.branch_target = t;
        bus.branch_taken  = 1'b1;
        step();
        bus.branch_taken  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) & 16'h3FFF;
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        mem[16'h0012] = 16'hC0F0;
        mem[16'h0032] = 16'hC0F0;
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 16'h0000;
        step(); step();

        // reset values
        chk_f("rst", 16'hC0E0, 16'h0000, 1'b0);
        check("rst.halted", 32'(bus.halted), 32'd0);
        check("rst.addr", 32'(bus.imem_addr), 32'h0);
        rst_n = 1'b1;

        // streaming from reset
        step(); chk_f("boot1", 16'hC0E0, 16'h0000, 1'b0);
        check("boot1.addr", 32'(bus.imem_addr), 32'h1);
        step(); chk_f("boot2", 16'h1111, 16'h0000, 1'b1);
        step(); chk_f("boot3", 16'h2222, 16'h0001, 1'b1);
        step(); chk_f("boot4", 16'h3333, 16'h0002, 1'b1);
        step(); chk_f("boot5", 16'h4444, 16'h0003, 1'b1);
        check("boot5.addr", 32'(bus.imem_addr), 32'h5);

        // stall 3 cycles with mem[4] in flight
        bus.stall = 1'b1;
        step(); chk_f("stall1", 16'h4444, 16'h0003, 1'b1);
        step(); chk_f("stall2", 16'h4444, 16'h0003, 1'b1);
        step(); chk_f("stall3", 16'h4444, 16'h0003, 1'b1);
        check("stall.addr", 32'(bus.imem_addr), 32'h5);
        bus.stall = 1'b0;
        step(); chk_f("unst1", 16'h0004, 16'h0004, 1'b1);
        step(); chk_f("unst2", 16'h0005, 16'h0005, 1'b1);
        step(); chk_f("unst3", 16'h0006, 16'h0006, 1'b1);

        // redirect to 0x40 while mem[7] is in flight
        branch(16'h0040);
        chk_f("br1", 16'hC0E0, 16'h0006, 1'b0);
        check("br1.addr", 32'(bus.imem_addr), 32'h40);
        step(); check("br2.valid", 32'(bus.inst_valid), 32'd0);
        step(); chk_f("br3", 16'h0040, 16'h0040, 1'b1);
        step(); chk_f("br4", 16'h0041, 16'h0041, 1'b1);

        // branch together with stall: branch wins
        bus.stall = 1'b1;
        branch(16'h0080);
        bus.stall = 1'b0;
        chk_f("brst1", 16'hC0E0, 16'h0041, 1'b0);
        check("brst1.addr", 32'(bus.imem_addr), 32'h80);
        step(); check("brst2.valid", 32'(bus.inst_valid), 32'd0);
        step(); chk_f("brst3", 16'h0080, 16'h0080, 1'b1);

        // HLT at 0x12
        branch(16'h0010);
        step(); step(); chk_f("h3", 16'h0010, 16'h0010, 1'b1);
        step(); chk_f("h4", 16'h0011, 16'h0011, 1'b1);
        check("h4.halted", 32'(bus.halted), 32'd0);
        step(); chk_f("hlt", 16'hC0F0, 16'h0012, 1'b1);
        check("hlt.halted", 32'(bus.halted), 32'd1);
        check("hlt.addr", 32'(bus.imem_addr), 32'h13);
        step(); chk_f("hd1", 16'hC0E0, 16'h0012, 1'b0);
        check("hd1.halted", 32'(bus.halted), 32'd1);
        step(); chk_f("hd2", 16'hC0E0, 16'h0012, 1'b0);
        check("hd2.addr", 32'(bus.imem_addr), 32'h13);
        branch(16'h0020);
        check("hbr.halted", 32'(bus.halted), 32'd0);
        step(); step(); chk_f("hbr3", 16'h0020, 16'h0020, 1'b1);

        // branch on the edge where HLT would load
        branch(16'h0030);
        step(); step(); step(); chk_f("bh4", 16'h0031, 16'h0031, 1'b1);
        branch(16'h0050);
        chk_f("bh5", 16'hC0E0, 16'h0031, 1'b0);
        check("bh5.halted", 32'(bus.halted), 32'd0);
        step(); step(); chk_f("bh7", 16'h0050, 16'h0050, 1'b1);

        // PC wrap
        branch(16'hFFFE);
        step(); step(); chk_f("wr3", 16'h3FFE, 16'hFFFE, 1'b1);
        check("wr3.addr", 32'(bus.imem_addr), 32'h0);
        step(); chk_f("wr4", 16'h3FFF, 16'hFFFF, 1'b1);
        step(); chk_f("wr5", 16'h1111, 16'h0000, 1'b1);

        // async reset mid-stall with skid full
        bus.stall = 1'b1;
        step(); chk_f("rs0", 16'h1111, 16'h0000, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_f("arst", 16'hC0E0, 16'h0000, 1'b0);
        check("arst.addr", 32'(bus.imem_addr), 32'h0);
        check("arst.halted", 32'(bus.halted), 32'd0);
        bus.stall = 1'b0;
        step();
        rst_n = 1'b1;
        step(); check("rr1.valid", 32'(bus.inst_valid), 32'd0);
        step(); chk_f("rr2", 16'h1111, 16'h0000, 1'b1);
        step(); chk_f("rr3", 16'h2222, 16'h0001, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
